multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the ARM-subset processor. Replaces single-cycle decode timing with an FSM.

---
 rtl/proc_ctrl_pkg.sv | 54 +++++
 rtl/mem_timeout_cnt.sv | 39 +++
 rtl/multicycle_ctrl_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// proc_ctrl_pkg
// Shared types and encodings for the multi-cycle control sequencer of the
// ARM-subset processor: controller state enum, instruction class codes
// (instr[27:26]) and the select encodings driven onto the datapath muxes.
// -----------------------------------------------------------------------------
package proc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXECR    = 4'd3,
    S_EXECI    = 4'd4,
    S_ALUWB    = 4'd5,
    S_MEMADR   = 4'd6,
    S_MEMREAD  = 4'd7,
    S_MEMWB    = 4'd8,
    S_MEMWRITE = 4'd9,
    S_BRANCH   = 4'd10
  } ctrl_state_t;

  // Instruction classes, instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // ALU operand B select
  localparam logic [1:0] ALU_B_REG  = 2'b00;
  localparam logic [1:0] ALU_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_B_FOUR = 2'b10;

  // Register write-back source
  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALUOUT = 2'b10;

  // Immediate extension format
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Register-file read address overrides
  localparam logic [1:0] REG_SRC_NONE = 2'b00;
  localparam logic [1:0] REG_SRC_PC   = 2'b01;  // Rn = R15
  localparam logic [1:0] REG_SRC_RD   = 2'b10;  // Rm = Rd, store data

  // States that own the shared memory port (mem_req is high in these)
  function automatic logic state_uses_mem(input ctrl_state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// -----------------------------------------------------------------------------
// mem_timeout_cnt
// Counts cycles a memory request has been outstanding without acknowledge.
// o_expired is high while the count equals MEM_TIMEOUT; the controller then
// abandons the access unless mem_ack arrives in that same cycle.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   i_clr      in   clear count (state change or abandoned access)
//   i_inc      in   request pending without ack this cycle
//   o_expired  out  count has reached MEM_TIMEOUT
// -----------------------------------------------------------------------------
module mem_timeout_cnt #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [TO_W-1:0] r_cnt;

  assign o_expired = (r_cnt == TO_W'(MEM_TIMEOUT));

  // Hold at MEM_TIMEOUT so a maximal MEM_TIMEOUT cannot wrap to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_expired) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multi-cycle control sequencer for the ARM-subset processor. One unified
// memory port is shared between instruction fetch and LDR/STR data access
// using a req/ack handshake; datapath enables and selects are driven per phase.
// Optional feature macro: CTRL_PERF_CNT_EN adds o_cyc_cnt / o_instr_cnt.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_op[1:0]       instr[27:26] class
//   i_funct[5:0]    instr[25:20]; [5]=I, [0]=L
//   i_cond_ex       condition check result (used in DECODE)
//   i_mem_ack       memory completes current access
//   o_mem_req/o_mem_we/o_adr_src   memory port control
//   o_ir_write/o_pc_write/o_reg_write  write enables
//   o_alu_src_b/o_result_src/o_imm_src/o_reg_src/o_alu_op  datapath selects
//   o_bus_err       1-cycle pulse on memory timeout
//   o_illegal       1-cycle pulse on op=11 in DECODE
//   o_cyc_cnt/o_instr_cnt  (CTRL_PERF_CNT_EN only) performance counters
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_op,
  input  logic [5:0]  i_funct,
  input  logic        i_cond_ex,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_adr_src,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_reg_write,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_result_src,
  output logic [1:0]  o_imm_src,
  output logic [1:0]  o_reg_src,
  output logic        o_alu_op,
  output logic        o_bus_err,
  output logic        o_illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] o_cyc_cnt,
  output logic [31:0] o_instr_cnt
`endif
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;

  logic w_req_state;
  logic w_expired;
  logic w_timeout;
  logic w_inc;
  logic w_clr;

  // Only I (bit 5) and L (bit 0) steer the sequence; the rest belongs to the ALU.
  logic w_unused_funct;
  assign w_unused_funct = ^i_funct[4:1];

  // An ack outside a requesting state is ignored entirely.
  assign w_req_state = state_uses_mem(r_state);
  assign w_inc       = w_req_state && !i_mem_ack;
  // Ack in the expiry cycle wins over the timeout.
  assign w_timeout   = w_req_state && w_expired && !i_mem_ack;
  // A FETCH timeout stays in FETCH, so the count must be cleared explicitly.
  assign w_clr       = (w_state_next != r_state) || w_timeout;

  mem_timeout_cnt #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_inc     (w_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_b  = ALU_B_REG;
    o_result_src = RES_ALU;
    o_imm_src    = IMM_DP;
    o_reg_src    = REG_SRC_NONE;
    o_alu_op     = 1'b0;
    o_bus_err    = 1'b0;
    o_illegal    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end

      S_FETCH: begin
        // ALU computes PC+4 while the instruction word is read.
        o_mem_req   = 1'b1;
        o_alu_src_b = ALU_B_FOUR;
        if (i_mem_ack) begin
          o_ir_write   = 1'b1;
          o_pc_write   = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          // Re-fetch the same PC: nothing was written.
          o_bus_err    = 1'b1;
          w_state_next = S_FETCH;
        end
      end

      S_DECODE: begin
        if (!i_cond_ex) begin
          w_state_next = S_FETCH;
        end else begin
          unique case (i_op)
            OP_DP:   w_state_next = i_funct[5] ? S_EXECI : S_EXECR;
            OP_MEM:  w_state_next = S_MEMADR;
            OP_BR:   w_state_next = S_BRANCH;
            OP_ILL: begin
              o_illegal    = 1'b1;
              w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
          endcase
        end
      end

      S_EXECR: begin
        o_alu_op     = 1'b1;
        o_alu_src_b  = ALU_B_REG;
        w_state_next = S_ALUWB;
      end

      S_EXECI: begin
        o_alu_op     = 1'b1;
        o_alu_src_b  = ALU_B_IMM;
        o_imm_src    = IMM_DP;
        w_state_next = S_ALUWB;
      end

      S_ALUWB: begin
        o_reg_write  = 1'b1;
        o_result_src = RES_ALUOUT;
        w_state_next = S_FETCH;
      end

      S_MEMADR: begin
        o_imm_src    = IMM_MEM;
        o_alu_src_b  = ALU_B_IMM;
        w_state_next = i_funct[0] ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
        if (i_mem_ack) begin
          w_state_next = S_MEMWB;
        end else if (w_timeout) begin
          o_bus_err    = 1'b1;
          w_state_next = S_FETCH;
        end
      end

      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_result_src = RES_MEM;
        w_state_next = S_FETCH;
      end

      S_MEMWRITE: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        o_adr_src = 1'b1;
        o_reg_src = REG_SRC_RD;
        if (i_mem_ack) begin
          w_state_next = S_FETCH;
        end else if (w_timeout) begin
          o_bus_err    = 1'b1;
          w_state_next = S_FETCH;
        end
      end

      S_BRANCH: begin
        o_imm_src    = IMM_BR;
        o_reg_src    = REG_SRC_PC;
        o_pc_write   = 1'b1;
        w_state_next = S_FETCH;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_instr_cnt;
  logic        w_retire;

  // Retirement = re-entering FETCH from an instruction phase. The reset
  // start-up (IDLE) and a re-fetch after a fetch timeout are not retirements.
  assign w_retire = (w_state_next == S_FETCH) &&
                    (r_state != S_IDLE) && (r_state != S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt   <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end

  assign o_cyc_cnt   = r_cyc_cnt;
  assign o_instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Table-driven instruction vectors run through a scoreboard queue, plus
// hand-written sequences for reset, fetch timeout and ignored ack.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        cond_ex;
  logic        mem_ack;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_b, result_src, imm_src, reg_src;
  logic        alu_op, bus_err, illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  logic [16:0] outs;
  assign outs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                 alu_src_b, result_src, imm_src, reg_src, alu_op, bus_err, illegal};

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_op         (op),
    .i_funct      (funct),
    .i_cond_ex    (cond_ex),
    .i_mem_ack    (mem_ack),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_adr_src    (adr_src),
    .o_ir_write   (ir_write),
    .o_pc_write   (pc_write),
    .o_reg_write  (reg_write),
    .o_alu_src_b  (alu_src_b),
    .o_result_src (result_src),
    .o_imm_src    (imm_src),
    .o_reg_src    (reg_src),
    .o_alu_op     (alu_op),
    .o_bus_err    (bus_err),
    .o_illegal    (illegal)
`ifdef CTRL_PERF_CNT_EN
    ,
    .o_cyc_cnt    (cyc_cnt),
    .o_instr_cnt  (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction: stimulus, memory wait states (255 = never ack) and the
  // expected per-instruction observations.
  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    logic       cond;
    int         fwait;
    int         dwait;
    int         cycles;
    int         rw;
    int         pcw;
    int         irw;
    int         ill;
    int         berr;
    int         we_acc;
    int         dreq;
    logic [1:0] rs_wb;     // result_src seen with reg_write (3 = none)
    logic [1:0] exec_b;    // alu_src_b seen with alu_op (3 = none)
    logic [1:0] imm_or;    // OR of imm_src over the instruction
    logic [1:0] regsrc_or; // OR of reg_src over the instruction
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];
  vec_t sb_q[$];

  int checks = 0;
  int errors = 0;

  int         ob_cycles, ob_rw, ob_pcw, ob_irw, ob_ill, ob_berr, ob_we, ob_dreq;
  logic [1:0] ob_rs_wb, ob_exec_b, ob_imm_or, ob_regsrc_or;

  task automatic chk(input string nm, input string f, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s got %0d want %0d", nm, f, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in a fresh FETCH; returns at the negedge
  // where the next FETCH begins.
  task automatic run_vec(input vec_t v);
    int   run_cnt;
    int   cyc;
    logic fetch;
    logic prev_fetch;
    op = v.op; funct = v.funct; cond_ex = v.cond;
    ob_rw = 0; ob_pcw = 0; ob_irw = 0; ob_ill = 0; ob_berr = 0; ob_we = 0; ob_dreq = 0;
    ob_rs_wb = 2'b11; ob_exec_b = 2'b11; ob_imm_or = 2'b00; ob_regsrc_or = 2'b00;
    run_cnt = 0; cyc = 0; prev_fetch = 1'b0;
    while (cyc < 64) begin
      fetch = mem_req && !adr_src;
      if (cyc > 0 && fetch && !prev_fetch) break;
      mem_ack = mem_req && (run_cnt == (adr_src ? v.dwait : v.fwait));
      #1;
      if (reg_write) begin ob_rw++; ob_rs_wb = result_src; end
      if (pc_write)  ob_pcw++;
      if (ir_write)  ob_irw++;
      if (illegal)   ob_ill++;
      if (bus_err)   ob_berr++;
      if (mem_we && mem_ack) ob_we++;
      if (mem_req && adr_src) ob_dreq++;
      if (alu_op) ob_exec_b = alu_src_b;
      ob_imm_or    = ob_imm_or | imm_src;
      ob_regsrc_or = ob_regsrc_or | reg_src;
      if (mem_req && !mem_ack && !bus_err) run_cnt++;
      else run_cnt = 0;
      prev_fetch = fetch;
      cyc++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    ob_cycles = cyc;
  endtask

  task automatic run_and_score(input vec_t v);
    vec_t e;
    sb_q.push_back(v);
    run_vec(v);
    e = sb_q.pop_front();
    $display("TXN %s cycles=%0d rw=%0d pcw=%0d berr=%0d ill=%0d dreq=%0d",
             e.name, ob_cycles, ob_rw, ob_pcw, ob_berr, ob_ill, ob_dreq);
    chk(e.name, "cycles", ob_cycles, e.cycles);
    chk(e.name, "reg_write", ob_rw, e.rw);
    chk(e.name, "pc_write", ob_pcw, e.pcw);
    chk(e.name, "ir_write", ob_irw, e.irw);
    chk(e.name, "illegal", ob_ill, e.ill);
    chk(e.name, "bus_err", ob_berr, e.berr);
    chk(e.name, "we_accepted", ob_we, e.we_acc);
    chk(e.name, "data_req_cycles", ob_dreq, e.dreq);
    chk(e.name, "wb_result_src", int'(ob_rs_wb), int'(e.rs_wb));
    chk(e.name, "exec_alu_src_b", int'(ob_exec_b), int'(e.exec_b));
    chk(e.name, "imm_src", int'(ob_imm_or), int'(e.imm_or));
    chk(e.name, "reg_src", int'(ob_regsrc_or), int'(e.regsrc_or));
  endtask

  initial begin
    int berr_at;
    int berr_n;
    int req_n;
    int irw_n;

    //         name     op     funct      c  fw  dw  cyc rw pcw irw ill be we dreq rs_wb  exec_b imm    regsrc
    vecs[0]  = '{"ADDr",  2'b00, 6'b000000, 1, 0, 0,   4, 1, 1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{"ADDi",  2'b00, 6'b100000, 1, 0, 0,   4, 1, 1, 1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00};
    vecs[2]  = '{"ADDf2", 2'b00, 6'b000000, 1, 2, 0,   6, 1, 1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{"LDR0",  2'b01, 6'b011001, 1, 0, 0,   5, 1, 1, 1, 0, 0, 0, 1, 2'b01, 2'b11, 2'b01, 2'b00};
    vecs[4]  = '{"LDR3",  2'b01, 6'b011001, 1, 0, 3,   8, 1, 1, 1, 0, 0, 0, 4, 2'b01, 2'b11, 2'b01, 2'b00};
    vecs[5]  = '{"STR0",  2'b01, 6'b011000, 1, 0, 0,   4, 0, 1, 1, 0, 0, 1, 1, 2'b11, 2'b11, 2'b01, 2'b10};
    vecs[6]  = '{"STR2",  2'b01, 6'b011000, 1, 0, 2,   6, 0, 1, 1, 0, 0, 1, 3, 2'b11, 2'b11, 2'b01, 2'b10};
    vecs[7]  = '{"B",     2'b10, 6'b000000, 1, 0, 0,   3, 0, 2, 1, 0, 0, 0, 0, 2'b11, 2'b11, 2'b10, 2'b01};
    vecs[8]  = '{"Bnc",   2'b10, 6'b000000, 0, 0, 0,   2, 0, 1, 1, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00};
    vecs[9]  = '{"ILL",   2'b11, 6'b000000, 1, 0, 0,   2, 0, 1, 1, 1, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00};
    vecs[10] = '{"ILLnc", 2'b11, 6'b000000, 0, 0, 0,   2, 0, 1, 1, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00};
    vecs[11] = '{"STRto", 2'b01, 6'b011000, 1, 0, 255, 19, 0, 1, 1, 0, 1, 0, 16, 2'b11, 2'b11, 2'b01, 2'b10};
    vecs[12] = '{"LDRto", 2'b01, 6'b011001, 1, 0, 255, 19, 0, 1, 1, 0, 1, 0, 16, 2'b11, 2'b11, 2'b01, 2'b00};
    vecs[13] = '{"LDRedge",2'b01,6'b011001, 1, 0, 15, 20, 1, 1, 1, 0, 0, 0, 16, 2'b01, 2'b11, 2'b01, 2'b00};
    vecs[14] = '{"STRedge",2'b01,6'b011000, 1, 0, 15, 19, 0, 1, 1, 0, 0, 1, 16, 2'b11, 2'b11, 2'b01, 2'b10};

    rst = 1'b1; op = 2'b00; funct = 6'd0; cond_ex = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset", "outs", int'(outs), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle", "outs", int'(outs), 0);
    @(negedge clk);
    chk("idle_to_fetch", "mem_req", int'(mem_req), 1);

`ifdef CTRL_PERF_CNT_EN
    for (int i = 0; i < 3; i++) run_and_score(vecs[7]);
    chk("perf", "instr_cnt", int'(instr_cnt), 3);
    chk("perf", "cyc_cnt", int'(cyc_cnt), 10);
`endif

    for (int i = 0; i < NV; i++) run_and_score(vecs[i]);

    // Fetch never acknowledged: bus_err in the 16th request cycle, then re-fetch.
    mem_ack = 1'b0; cond_ex = 1'b0;
    berr_at = -1; berr_n = 0; req_n = 0; irw_n = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus_err) begin berr_at = i; berr_n++; end
      if (mem_req && !adr_src) req_n++;
      if (ir_write || pc_write) irw_n++;
      @(negedge clk);
    end
    $display("TXN FETCHto bus_err_at=%0d pulses=%0d", berr_at, berr_n);
    chk("fetch_to", "bus_err_cycle", berr_at, 15);
    chk("fetch_to", "bus_err_pulses", berr_n, 1);
    chk("fetch_to", "req_cycles", req_n, 16);
    chk("fetch_to", "ir_pc_writes", irw_n, 0);
    #1 chk("fetch_to", "refetch_req", int'(mem_req && !adr_src), 1);
    chk("fetch_to", "count_restart", int'(bus_err), 0);
    @(negedge clk);
    mem_ack = 1'b1;
    #1 chk("fetch_to", "refetch_ir_write", int'(ir_write), 1);
    @(negedge clk);
    // DECODE: an ack with no request outstanding must have no effect.
    #1 chk("ack_ignored", "outs", int'(outs), 0);
    @(negedge clk);
    mem_ack = 1'b0;
    $display("TXN ACKIGN outs=%0h", outs);

    // Reset in the middle of a fetch.
    #1 chk("rst_mid", "req_before", int'(mem_req), 1);
    rst = 1'b1;
    #1 chk("rst_mid", "outs_async", int'(outs), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid", "idle_outs", int'(outs), 0);
    @(negedge clk);
    #1 chk("rst_mid", "fetch_req", int'(mem_req), 1);
`ifdef CTRL_PERF_CNT_EN
    chk("rst_mid", "cyc_cnt", int'(cyc_cnt), 1);
    chk("rst_mid", "instr_cnt", int'(instr_cnt), 0);
`endif
    $display("TXN RSTMID done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
